mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory stage of the RISC-V pipeline; consumes the execute stage's outputs: address from alu_result, store data from rs2_data, plus mem_op, mem_sel and the writeback controls.
- Drives a single-outstanding request/ready data-memory bus and stalls upstream while a transfer is pending.
- Byte-aligns and sign/zero-extends load data, builds store byte strobes, detects misalignment and bus timeout.
- Presents a registered bundle to writeback.

Parameters:
TIMEOUT_CYCLES, 16, BUSY cycles without dmem_ready before the access is aborted (>=1)
CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  execute bundle valid
in_ready  out  1  unit can accept a bundle this cycle
alu_result  in  32  effective address / ALU result
rs2_data  in  32  store data
mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
mem_sel  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
wb_sel_in  in  2  writeback source select, passed through
rd_in  in  5  destination register
reg_we_in  in  1  register write enable
pc_next_in  in  32  pass-through
pc_adder_result_in  in  32  pass-through
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, bits[1:0] = 0
dmem_wdata  out  32  lane-shifted store data
dmem_wstrb  out  4  byte strobes
dmem_ready  in  1  bus completes the transfer this cycle
dmem_rdata  in  32  read word, valid with dmem_ready
wb_valid  out  1  writeback bundle valid, one-cycle pulse
wb_rd, wb_reg_we, wb_sel, wb_alu_result, wb_pc_next, wb_pc_adder_result  out  5/1/2/32/32/32  registered pass-through
wb_load_data  out  32  extended load value
wb_err  out  2  00 ok, 01 misaligned, 10 timeout

Behaviour:
- Reset: state IDLE; counter 0; all outputs 0 except in_ready, which is 1.
- FSM states: IDLE, BUSY.
- in_ready = (state == IDLE). A bundle is accepted on in_valid && in_ready.
- Alignment rules:
  - H/HU: misaligned if addr[0] = 1.
  - W: misaligned if addr[1:0] != 0.
  - Any unlisted mem_sel: treated as W.
- IDLE, accepted bundle, by case:
  - Non-memory op: next cycle wb_valid = 1, wb_err = 00, wb_load_data = 0, pass-throughs registered. State stays IDLE, so back-to-back accepts are allowed.
  - Misaligned load/store: no bus activity. Next cycle wb_valid = 1, wb_err = 01, wb_reg_we = 0. State stays IDLE.
  - Aligned load/store: latch the bundle, go to BUSY, counter = 0.
- BUSY:
  - dmem_req = 1.
  - dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are held stable from latched values until completion.
  - dmem_wstrb is 0 for loads.
- Completion (dmem_req && dmem_ready):
  - Next cycle wb_valid = 1, wb_err = 00; return to IDLE.
  - Loads: the selected byte/halfword lane of dmem_rdata goes to wb_load_data, sign-extended for B/H, zero-extended for BU/HU.
- Timeout:
  - Counter increments each BUSY cycle without ready.
  - When counter == TIMEOUT_CYCLES-1 and dmem_ready = 0: drop req, next cycle wb_valid = 1, wb_err = 10, wb_reg_we = 0, return to IDLE.
  - Ready arriving on that same cycle wins: normal completion.
- Store lanes:
  - B: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - W: wdata = rs2, wstrb = 1111.
- wb_valid is 0 in every cycle not listed above; other wb_* outputs hold their last value.
- Latency from acceptance to wb_valid:
  - Non-memory op: 1 cycle.
  - Memory op: 1 + N cycles, where N >= 1 is the number of BUSY cycles up to and including the ready cycle (so 2 cycles minimum).
- rst while BUSY: req drops in the cycle after reset is sampled, no wb_valid is produced, state IDLE. The bus slave is also reset by the same rst.

Decomposition:
- Shared package (rv_pkg): MEM_OP_NONE/LOAD/STORE, MEM_SEL_B/H/W/BU/HU encodings, WB_ERR_* codes, and FSM state encoding.
- One combinational sub-module, load_store_align: {addr[1:0], mem_sel, rs2, rdata} -> {wdata, wstrb, load_data, misaligned}. The FSM, counter and registers stay in mem_access_unit.

Test Plan:
- mem_op = 00, alu_result = 0x1234 on consecutive cycles -> wb_valid each following cycle, wb_alu_result = 0x1234, in_ready stays 1, dmem_req never asserted.
- Load LB at 0x103, bus returns rdata = 0x80FF_FF7F after 3 BUSY cycles -> addr = 0x100, req held exactly 3 cycles, wb_load_data = 0xFFFF_FF80, in_ready = 0 throughout BUSY.
- Store SH at 0x202, rs2 = 0xABCD_1234, immediate ready -> wdata = 0x1234_1234, wstrb = 1100, we = 1, wb_valid 2 cycles after accept.
- LW at 0x101 -> no dmem_req, wb_err = 01, wb_reg_we = 0; LHU at 0x102 with rdata = 0xBEEF_0000 -> wb_load_data = 0x0000_BEEF.
- TIMEOUT_CYCLES = 4, dmem_ready tied 0 -> req high exactly 4 cycles, then wb_err = 10, wb_reg_we = 0, in_ready = 1; repeat with ready in 4th cycle -> wb_err = 00.
- rst asserted in 2nd BUSY cycle -> req = 0, in_ready = 1, wb_valid = 0 next cycle; a following non-memory op completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared encodings for the memory stage
// Memory op, access size (funct3), writeback error codes and FSM state encodings.
package rv_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_SEL_B  = 3'b000;
    localparam logic [2:0] MEM_SEL_H  = 3'b001;
    localparam logic [2:0] MEM_SEL_W  = 3'b010;
    localparam logic [2:0] MEM_SEL_BU = 3'b100;
    localparam logic [2:0] MEM_SEL_HU = 3'b101;

    localparam logic [1:0] WB_ERR_OK         = 2'b00;
    localparam logic [1:0] WB_ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] WB_ERR_TIMEOUT    = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering for stores and extension for loads
// Ports:
//   addr_lo    in   byte offset within the word
//   mem_sel    in   access size / signedness (funct3)
//   rs2        in   raw store data
//   rdata      in   raw read word from the bus
//   wdata      out  store data replicated onto the addressed lanes
//   wstrb      out  byte strobes for a store
//   load_data  out  selected lane, sign- or zero-extended
//   misaligned out  access crosses its natural alignment
module load_store_align
    import rv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_sel,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Unlisted encodings fall through to the word defaults.
    always_comb begin
        wdata      = rs2;
        wstrb      = 4'b1111;
        load_data  = rdata;
        misaligned = (addr_lo != 2'b00);
        case (mem_sel)
            MEM_SEL_B, MEM_SEL_BU: begin
                wdata      = {4{rs2[7:0]}};
                wstrb      = 4'b0001 << addr_lo;
                load_data  = (mem_sel == MEM_SEL_B) ? {{24{byte_lane[7]}}, byte_lane}
                                                    : {24'd0, byte_lane};
                misaligned = 1'b0;
            end
            MEM_SEL_H, MEM_SEL_HU: begin
                wdata      = {2{rs2[15:0]}};
                wstrb      = 4'b0011 << addr_lo;
                load_data  = (mem_sel == MEM_SEL_H) ? {{16{half_lane[15]}}, half_lane}
                                                    : {16'd0, half_lane};
                misaligned = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RISC-V memory stage with single-outstanding data bus
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              execute bundle handshake
//   alu_result, rs2_data, mem_op, mem_sel, wb_sel_in, rd_in, reg_we_in,
//   pc_next_in, pc_adder_result_in execute bundle
//   dmem_req/we/addr/wdata/wstrb   data bus request, held while busy
//   dmem_ready/rdata               data bus completion and read word
//   wb_*                           registered writeback bundle, wb_valid pulses once
module mem_access_unit
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_sel,
    input  logic [1:0]  wb_sel_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_we_in,
    input  logic [31:0] pc_next_in,
    input  logic [31:0] pc_adder_result_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_pc_next,
    output logic [31:0] wb_pc_adder_result,
    output logic [31:0] wb_load_data,
    output logic [1:0]  wb_err
);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [31:0] alu_q, wdata_q, pc_next_q, pc_add_q;
    logic [3:0]  wstrb_q;
    logic        we_q, reg_we_q;
    logic [2:0]  sel_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_sel_q;

    logic        busy, accept, is_mem, timeout_hit;
    logic [31:0] al_wdata, al_load_data;
    logic [3:0]  al_wstrb;
    logic        al_misaligned;

    assign busy        = (state == ST_BUSY);
    assign in_ready    = (state == ST_IDLE);
    assign accept      = in_valid && in_ready;
    assign is_mem      = (mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // One aligner serves both phases: in IDLE it inspects the incoming
    // bundle (strobes, misalignment); in BUSY it extends the returning word
    // using the latched offset and size.
    load_store_align u_align (
        .addr_lo    (busy ? alu_q[1:0] : alu_result[1:0]),
        .mem_sel    (busy ? sel_q : mem_sel),
        .rs2        (rs2_data),
        .rdata      (dmem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load_data),
        .misaligned (al_misaligned)
    );

    // Bus outputs are zeroed outside BUSY so the bus sees a clean idle.
    assign dmem_req   = busy;
    assign dmem_we    = busy & we_q;
    assign dmem_addr  = busy ? {alu_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = busy ? wdata_q : 32'd0;
    assign dmem_wstrb = busy ? wstrb_q : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            alu_q              <= '0;
            wdata_q            <= '0;
            wstrb_q            <= '0;
            we_q               <= 1'b0;
            sel_q              <= '0;
            rd_q               <= '0;
            reg_we_q           <= 1'b0;
            wb_sel_q           <= '0;
            pc_next_q          <= '0;
            pc_add_q           <= '0;
            wb_valid           <= 1'b0;
            wb_rd              <= '0;
            wb_reg_we          <= 1'b0;
            wb_sel             <= '0;
            wb_alu_result      <= '0;
            wb_pc_next         <= '0;
            wb_pc_adder_result <= '0;
            wb_load_data       <= '0;
            wb_err             <= WB_ERR_OK;
        end else begin
            wb_valid <= 1'b0;
            if (!busy) begin
                if (accept && is_mem && !al_misaligned) begin
                    state     <= ST_BUSY;
                    cnt       <= '0;
                    alu_q     <= alu_result;
                    sel_q     <= mem_sel;
                    we_q      <= (mem_op == MEM_OP_STORE);
                    wdata_q   <= al_wdata;
                    wstrb_q   <= (mem_op == MEM_OP_STORE) ? al_wstrb : 4'd0;
                    rd_q      <= rd_in;
                    reg_we_q  <= reg_we_in;
                    wb_sel_q  <= wb_sel_in;
                    pc_next_q <= pc_next_in;
                    pc_add_q  <= pc_adder_result_in;
                end else if (accept) begin
                    // Non-memory op, or a memory op rejected for misalignment.
                    wb_valid           <= 1'b1;
                    wb_rd              <= rd_in;
                    wb_sel             <= wb_sel_in;
                    wb_alu_result      <= alu_result;
                    wb_pc_next         <= pc_next_in;
                    wb_pc_adder_result <= pc_adder_result_in;
                    wb_load_data       <= 32'd0;
                    wb_err             <= is_mem ? WB_ERR_MISALIGNED : WB_ERR_OK;
                    wb_reg_we          <= reg_we_in && !is_mem;
                end
            end else if (dmem_ready || timeout_hit) begin
                // Ready on the final counted cycle still completes normally.
                state              <= ST_IDLE;
                wb_valid           <= 1'b1;
                wb_rd              <= rd_q;
                wb_sel             <= wb_sel_q;
                wb_alu_result      <= alu_q;
                wb_pc_next         <= pc_next_q;
                wb_pc_adder_result <= pc_add_q;
                wb_load_data       <= (dmem_ready && !we_q) ? al_load_data : 32'd0;
                wb_err             <= dmem_ready ? WB_ERR_OK : WB_ERR_TIMEOUT;
                wb_reg_we          <= reg_we_q && dmem_ready;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] alu_result, rs2_data, pc_next_in, pc_adder_result_in;
    logic [1:0]  mem_op, wb_sel_in;
    logic [2:0]  mem_sel;
    logic [4:0]  rd_in;
    logic        reg_we_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_reg_we;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel, wb_err;
    logic [31:0] wb_alu_result, wb_pc_next, wb_pc_adder_result, wb_load_data;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .rs2_data(rs2_data), .mem_op(mem_op), .mem_sel(mem_sel),
        .wb_sel_in(wb_sel_in), .rd_in(rd_in), .reg_we_in(reg_we_in),
        .pc_next_in(pc_next_in), .pc_adder_result_in(pc_adder_result_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_sel(wb_sel),
        .wb_alu_result(wb_alu_result), .wb_pc_next(wb_pc_next),
        .wb_pc_adder_result(wb_pc_adder_result), .wb_load_data(wb_load_data), .wb_err(wb_err)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pcn;
        logic [31:0] pca;
        logic [31:0] ld;
        logic [1:0]  err;
    } wb_t;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_ld;
    } lane_t;

    wb_t exp_q[$];
    int  exp_cyc_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: lat is cycles from the accepting cycle to wb_valid.
    task automatic expect_wb(input logic [4:0] rd, input logic reg_we, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] ld,
                             input logic [1:0] err, input int lat);
        exp_q.push_back({rd, reg_we, sel, alu, alu + 32'd4, alu + 32'h100, ld, err});
        exp_cyc_q.push_back(cyc + lat);
    endtask

    task automatic set_bundle(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [4:0] rd, input logic reg_we,
                              input logic [1:0] wsel);
        in_valid           = 1'b1;
        mem_op             = op;
        mem_sel            = sel;
        alu_result         = addr;
        rs2_data           = rs2;
        rd_in              = rd;
        reg_we_in          = reg_we;
        wb_sel_in          = wsel;
        pc_next_in         = addr + 32'd4;
        pc_adder_result_in = addr + 32'h100;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic reg_we,
                         input logic [1:0] wsel);
        set_bundle(op, sel, addr, rs2, rd, reg_we, wsel);
        tick;
        in_valid = 1'b0;
        mem_op   = MEM_OP_NONE;
    endtask

    // Acts as the bus slave while dmem_req is high; ready_cycle < 0 never answers.
    task automatic run_bus(input int ready_cycle, input logic [31:0] rdata,
                           output int req_cycles, output logic [31:0] a, output logic w,
                           output logic [31:0] wd, output logic [3:0] ws,
                           output logic stable, output int rdy_hi);
        req_cycles = 0;
        stable     = 1'b1;
        rdy_hi     = 0;
        a  = dmem_addr;
        w  = dmem_we;
        wd = dmem_wdata;
        ws = dmem_wstrb;
        for (int c = 0; c < 40; c++) begin
            if (dmem_req !== 1'b1) break;
            req_cycles++;
            if ({dmem_addr, dmem_we, dmem_wdata, dmem_wstrb} !== {a, w, wd, ws}) stable = 1'b0;
            if (in_ready !== 1'b0) rdy_hi++;
            dmem_ready = (c == ready_cycle);
            dmem_rdata = rdata;
            tick;
        end
        dmem_ready = 1'b0;
    endtask

    // Writeback monitor: every wb_valid pulse must match the oldest expectation.
    initial begin
        wb_t act, exp_w;
        int  exp_c;
        forever begin
            @(posedge clk);
            #2;
            if (wb_valid === 1'b1) begin
                act = {wb_rd, wb_reg_we, wb_sel, wb_alu_result, wb_pc_next,
                       wb_pc_adder_result, wb_load_data, wb_err};
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL wb_unexpected: got wb_valid=1 bundle %h want no pulse", act);
                end else begin
                    exp_w = exp_q.pop_front();
                    exp_c = exp_cyc_q.pop_front();
                    if (act !== exp_w) $display("FAIL wb_bundle: got %h want %h", act, exp_w);
                    else pass_cnt++;
                    total_cnt++;
                    if (cyc !== exp_c) $display("FAIL wb_latency: got cycle %0d want %0d", cyc, exp_c);
                    else pass_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us want finish");
        $fatal(1);
    end

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== 70'd0)
            $display("FAIL reset_bus: got %h want 0", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb});
        else pass_cnt++;
        total_cnt++;
        if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid);
        else pass_cnt++;
        total_cnt++;
        if ({wb_rd, wb_reg_we, wb_sel, wb_alu_result, wb_pc_next, wb_pc_adder_result, wb_load_data, wb_err} !== 138'd0)
            $display("FAIL reset_wb_bundle: got nonzero want 0");
        else pass_cnt++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_non_mem;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL nonmem_in_ready[%0d]: got %b want 1", i, in_ready);
            else pass_cnt++;
            total_cnt++;
            if (dmem_req !== 1'b0) $display("FAIL nonmem_req[%0d]: got %b want 0", i, dmem_req);
            else pass_cnt++;
            expect_wb(5'(i + 1), 1'b1, 2'(i), 32'h1234, 32'd0, WB_ERR_OK, 1);
            set_bundle((i == 3) ? 2'b11 : MEM_OP_NONE, MEM_SEL_W, 32'h1234, 32'hFFFF_0000,
                       5'(i + 1), 1'b1, 2'(i));
            tick;
        end
        in_valid = 1'b0;
        mem_op   = MEM_OP_NONE;
        total_cnt++;
        if ({dmem_req, in_ready} !== 2'b01) $display("FAIL nonmem_after: got req,rdy=%b want 01", {dmem_req, in_ready});
        else pass_cnt++;
        tick;
    endtask

    task automatic test_load_lb;
        int r, hi;
        logic [31:0] a, wd;
        logic w, st;
        logic [3:0] ws;
        expect_wb(5'd5, 1'b1, 2'd1, 32'h103, 32'hFFFF_FF80, WB_ERR_OK, 4);
        issue(MEM_OP_LOAD, MEM_SEL_B, 32'h103, 32'd0, 5'd5, 1'b1, 2'd1);
        run_bus(2, 32'h80FF_FF7F, r, a, w, wd, ws, st, hi);
        total_cnt++;
        if (r !== 3) $display("FAIL lb_req_cycles: got %0d want 3", r);
        else pass_cnt++;
        total_cnt++;
        if ({a, w, ws} !== {32'h100, 1'b0, 4'd0}) $display("FAIL lb_bus: got addr=%h we=%b strb=%b want 100/0/0000", a, w, ws);
        else pass_cnt++;
        total_cnt++;
        if ({st, hi} !== {1'b1, 32'd0}) $display("FAIL lb_busy_hold: got stable=%b rdy_hi=%0d want 1/0", st, hi);
        else pass_cnt++;
        total_cnt++;
        if ({dmem_req, in_ready} !== 2'b01) $display("FAIL lb_done: got req,rdy=%b want 01", {dmem_req, in_ready});
        else pass_cnt++;
        tick;
    endtask

    task automatic test_store_sh;
        int r, hi;
        logic [31:0] a, wd;
        logic w, st;
        logic [3:0] ws;
        expect_wb(5'd0, 1'b0, 2'd0, 32'h202, 32'd0, WB_ERR_OK, 2);
        issue(MEM_OP_STORE, MEM_SEL_H, 32'h202, 32'hABCD_1234, 5'd0, 1'b0, 2'd0);
        run_bus(0, 32'd0, r, a, w, wd, ws, st, hi);
        total_cnt++;
        if ({a, w, wd, ws} !== {32'h200, 1'b1, 32'h1234_1234, 4'b1100})
            $display("FAIL sh_bus: got addr=%h we=%b wdata=%h strb=%b want 200/1/12341234/1100", a, w, wd, ws);
        else pass_cnt++;
        total_cnt++;
        if (r !== 1) $display("FAIL sh_req_cycles: got %0d want 1", r);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_misaligned;
        logic [2:0]  sels[3]  = '{MEM_SEL_W, MEM_SEL_H, MEM_SEL_H};
        logic [1:0]  ops[3]   = '{MEM_OP_LOAD, MEM_OP_STORE, MEM_OP_LOAD};
        logic [31:0] addrs[3] = '{32'h101, 32'h201, 32'h103};
        for (int i = 0; i < 3; i++) begin
            expect_wb(5'd9, 1'b0, 2'd1, addrs[i], 32'd0, WB_ERR_MISALIGNED, 1);
            issue(ops[i], sels[i], addrs[i], 32'h5A5A_5A5A, 5'd9, 1'b1, 2'd1);
            total_cnt++;
            if ({dmem_req, in_ready} !== 2'b01) $display("FAIL misal_idle[%0d]: got req,rdy=%b want 01", i, {dmem_req, in_ready});
            else pass_cnt++;
        end
        tick;
    endtask

    task automatic test_lane_table;
        lane_t tbl[8];
        int r, hi;
        logic [31:0] a, wd;
        logic w, st;
        logic [3:0] ws;
        logic is_st;
        tbl[0] = '{MEM_OP_LOAD,  MEM_SEL_HU, 32'h102, 32'd0, 32'hBEEF_0000, 32'h100, 32'd0, 4'b0000, 32'h0000_BEEF};
        tbl[1] = '{MEM_OP_LOAD,  MEM_SEL_H,  32'h102, 32'd0, 32'h8001_1234, 32'h100, 32'd0, 4'b0000, 32'hFFFF_8001};
        tbl[2] = '{MEM_OP_LOAD,  MEM_SEL_BU, 32'h101, 32'd0, 32'h0000_9A00, 32'h100, 32'd0, 4'b0000, 32'h0000_009A};
        tbl[3] = '{MEM_OP_LOAD,  MEM_SEL_B,  32'h100, 32'd0, 32'h0000_007F, 32'h100, 32'd0, 4'b0000, 32'h0000_007F};
        tbl[4] = '{MEM_OP_LOAD,  MEM_SEL_W,  32'h104, 32'd0, 32'hDEAD_BEEF, 32'h104, 32'd0, 4'b0000, 32'hDEAD_BEEF};
        tbl[5] = '{MEM_OP_STORE, MEM_SEL_B,  32'h203, 32'h1122_3355, 32'd0, 32'h200, 32'h5555_5555, 4'b1000, 32'd0};
        tbl[6] = '{MEM_OP_STORE, MEM_SEL_W,  32'h300, 32'hCAFE_F00D, 32'd0, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'd0};
        tbl[7] = '{MEM_OP_STORE, MEM_SEL_H,  32'h200, 32'h0000_BEEF, 32'd0, 32'h200, 32'hBEEF_BEEF, 4'b0011, 32'd0};
        for (int i = 0; i < 8; i++) begin
            is_st = (tbl[i].op == MEM_OP_STORE);
            expect_wb(5'(10 + i), !is_st, 2'd2, tbl[i].addr, tbl[i].exp_ld, WB_ERR_OK, 2 + (i % 2));
            issue(tbl[i].op, tbl[i].sel, tbl[i].addr, tbl[i].rs2, 5'(10 + i), !is_st, 2'd2);
            run_bus(i % 2, tbl[i].rdata, r, a, w, wd, ws, st, hi);
            total_cnt++;
            if ({a, w, ws} !== {tbl[i].exp_addr, is_st, tbl[i].exp_wstrb})
                $display("FAIL lane_bus[%0d]: got addr=%h we=%b strb=%b want %h/%b/%b", i, a, w, ws,
                         tbl[i].exp_addr, is_st, tbl[i].exp_wstrb);
            else pass_cnt++;
            total_cnt++;
            if (r !== 1 + (i % 2)) $display("FAIL lane_req_cycles[%0d]: got %0d want %0d", i, r, 1 + (i % 2));
            else pass_cnt++;
            if (is_st) begin
                total_cnt++;
                if (wd !== tbl[i].exp_wdata) $display("FAIL lane_wdata[%0d]: got %h want %h", i, wd, tbl[i].exp_wdata);
                else pass_cnt++;
            end
        end
        tick;
    endtask

    task automatic test_timeout;
        int r, hi;
        logic [31:0] a, wd;
        logic w, st;
        logic [3:0] ws;
        expect_wb(5'd7, 1'b0, 2'd3, 32'h400, 32'd0, WB_ERR_TIMEOUT, 5);
        issue(MEM_OP_LOAD, MEM_SEL_W, 32'h400, 32'd0, 5'd7, 1'b1, 2'd3);
        run_bus(-1, 32'h1111_2222, r, a, w, wd, ws, st, hi);
        total_cnt++;
        if (r !== 4) $display("FAIL timeout_req_cycles: got %0d want 4", r);
        else pass_cnt++;
        total_cnt++;
        if ({dmem_req, in_ready} !== 2'b01) $display("FAIL timeout_idle: got req,rdy=%b want 01", {dmem_req, in_ready});
        else pass_cnt++;
        tick;
        expect_wb(5'd8, 1'b1, 2'd3, 32'h404, 32'h3333_4444, WB_ERR_OK, 5);
        issue(MEM_OP_LOAD, MEM_SEL_W, 32'h404, 32'd0, 5'd8, 1'b1, 2'd3);
        run_bus(3, 32'h3333_4444, r, a, w, wd, ws, st, hi);
        total_cnt++;
        if (r !== 4) $display("FAIL late_ready_req_cycles: got %0d want 4", r);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_reset_busy;
        issue(MEM_OP_LOAD, MEM_SEL_W, 32'h500, 32'd0, 5'd3, 1'b1, 2'd1);
        tick;
        total_cnt++;
        if (dmem_req !== 1'b1) $display("FAIL rstbusy_pre_req: got %b want 1", dmem_req);
        else pass_cnt++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total_cnt++;
        if ({dmem_req, in_ready, wb_valid} !== 3'b010)
            $display("FAIL rstbusy_after: got req,rdy,wbv=%b want 010", {dmem_req, in_ready, wb_valid});
        else pass_cnt++;
        expect_wb(5'd4, 1'b1, 2'd0, 32'h77, 32'd0, WB_ERR_OK, 1);
        issue(MEM_OP_NONE, MEM_SEL_W, 32'h77, 32'd0, 5'd4, 1'b1, 2'd0);
        tick;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_op = MEM_OP_NONE; mem_sel = MEM_SEL_W;
        alu_result = '0; rs2_data = '0; wb_sel_in = '0; rd_in = '0; reg_we_in = 1'b0;
        pc_next_in = '0; pc_adder_result_in = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        test_reset;
        test_non_mem;
        test_load_lb;
        test_store_sh;
        test_misaligned;
        test_lane_table;
        test_timeout;
        test_reset_busy;
        tick;
        tick;
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
